// File: rtl/dm_sba_xfer.sv
// System bus access engine for the debug module: turns sbaddress/sbdata CSR
// activity into single bus transactions with lane steering, size/alignment
// checks, bus error reporting and a per-transaction timeout.
module dm_sba_xfer #(
  parameter int BusWidth      = 32,
  parameter int TimeoutCycles = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  dmactive_i,
  input  logic [BusWidth-1:0]   sbaddress_i,
  input  logic                  sbaddress_write_valid_i,
  input  logic                  sbreadonaddr_i,
  input  logic                  sbreadondata_i,
  input  logic                  sbautoincrement_i,
  input  logic [2:0]            sbaccess_i,
  input  logic [BusWidth-1:0]   sbdata_i,
  input  logic                  sbdata_write_valid_i,
  input  logic                  sbdata_read_valid_i,
  output logic [BusWidth-1:0]   sbaddress_o,
  output logic [BusWidth-1:0]   sbdata_o,
  output logic                  sbdata_valid_o,
  output logic                  sbbusy_o,
  output logic                  sberror_valid_o,
  output logic [2:0]            sberror_o,
  output logic                  sbbusyerror_o,
  output logic                  master_req_o,
  output logic [BusWidth-1:0]   master_add_o,
  output logic                  master_we_o,
  output logic [BusWidth-1:0]   master_wdata_o,
  output logic [BusWidth/8-1:0] master_be_o,
  input  logic                  master_gnt_i,
  input  logic                  master_r_valid_i,
  input  logic [BusWidth-1:0]   master_r_rdata_i,
  input  logic                  master_err_i
);

  localparam int BeW  = BusWidth / 8;
  localparam int OffW = $clog2(BeW);
  localparam int CntW = (TimeoutCycles < 2) ? 1 : $clog2(TimeoutCycles);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

  // Access size code to number of bytes (codes above 3 never reach the bus)
  function automatic logic [3:0] size_bytes(input logic [2:0] acc);
    case (acc)
      3'd0:    size_bytes = 4'd1;
      3'd1:    size_bytes = 4'd2;
      3'd2:    size_bytes = 4'd4;
      default: size_bytes = 4'd8;
    endcase
  endfunction

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [BusWidth-1:0] sbaddress_q, sbaddress_d;
  logic [BusWidth-1:0] sbdata_q, sbdata_d;
  logic                sbdata_valid_q, sbdata_valid_d;
  logic                sberror_valid_q, sberror_valid_d;
  logic [2:0]          sberror_q, sberror_d;
  logic                sbbusyerror_q, sbbusyerror_d;
  logic [BusWidth-1:0] add_q, add_d;
  logic                we_q, we_d;
  logic [BusWidth-1:0] wdata_q, wdata_d;
  logic [BeW-1:0]      be_q, be_d;
  logic [OffW-1:0]     off_q, off_d;
  logic [2:0]          acc_q, acc_d;
  logic                autoinc_q, autoinc_d;

  logic                wr_trig, rd_trig, any_trig;
  logic [BusWidth-1:0] eff_addr;
  logic [3:0]          req_bytes, cur_bytes;
  logic [OffW-1:0]     req_off;
  logic                size_ok, aligned, timeout_hit;
  logic [15:0]         mask_wide;
  logic [BeW-1:0]      lane_mask;
  logic [BusWidth-1:0] rdata_mask;

  // Next-state, transaction capture, completion and error handling
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    sbaddress_d     = sbaddress_q;
    sbdata_d        = sbdata_q;
    sbdata_valid_d  = 1'b0;
    sberror_valid_d = 1'b0;
    sberror_d       = sberror_q;
    sbbusyerror_d   = 1'b0;
    add_d           = add_q;
    we_d            = we_q;
    wdata_d         = wdata_q;
    be_d            = be_q;
    off_d           = off_q;
    acc_d           = acc_q;
    autoinc_d       = autoinc_q;

    wr_trig     = sbdata_write_valid_i;
    rd_trig     = (sbaddress_write_valid_i & sbreadonaddr_i) |
                  (sbdata_read_valid_i & sbreadondata_i);
    any_trig    = wr_trig | rd_trig;
    eff_addr    = sbaddress_write_valid_i ? sbaddress_i : sbaddress_q;
    req_bytes   = size_bytes(sbaccess_i);
    req_off     = eff_addr[OffW-1:0];
    size_ok     = (sbaccess_i <= 3'd3) && ((32'd8 << sbaccess_i) <= BusWidth);
    aligned     = (req_off & OffW'(req_bytes - 4'd1)) == '0;
    mask_wide   = (16'h1 << req_bytes) - 16'h1;
    lane_mask   = mask_wide[BeW-1:0];
    cur_bytes   = size_bytes(acc_q);
    rdata_mask  = ~({BusWidth{1'b1}} << {cur_bytes, 3'b000});
    timeout_hit = (TimeoutCycles != 0) && (cnt_q == CntW'(TimeoutCycles - 1));

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (dmactive_i) begin
          if (sbaddress_write_valid_i) sbaddress_d = sbaddress_i;
          if (any_trig) begin
            if (!size_ok) begin
              sberror_valid_d = 1'b1;
              sberror_d       = 3'd4;
            end else if (!aligned) begin
              sberror_valid_d = 1'b1;
              sberror_d       = 3'd3;
            end else begin
              state_d   = REQ;
              add_d     = {eff_addr[BusWidth-1:OffW], {OffW{1'b0}}};
              we_d      = wr_trig;
              wdata_d   = sbdata_i << {req_off, 3'b000};
              be_d      = lane_mask << req_off;
              off_d     = req_off;
              acc_d     = sbaccess_i;
              autoinc_d = sbautoincrement_i;
            end
          end
        end
      end
      default: begin
        if (!dmactive_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          if (any_trig || sbaddress_write_valid_i) sbbusyerror_d = 1'b1;
          cnt_d = cnt_q + CntW'(1);
          if (state_q == WAIT && master_r_valid_i) begin
            state_d = IDLE;
            cnt_d   = '0;
            if (master_err_i) begin
              sberror_valid_d = 1'b1;
              sberror_d       = 3'd2;
            end else begin
              if (!we_q) begin
                sbdata_d       = (master_r_rdata_i >> {off_q, 3'b000}) & rdata_mask;
                sbdata_valid_d = 1'b1;
              end
              if (autoinc_q) sbaddress_d = sbaddress_q + BusWidth'(cur_bytes);
            end
          end else if (timeout_hit) begin
            state_d         = IDLE;
            cnt_d           = '0;
            sberror_valid_d = 1'b1;
            sberror_d       = 3'd1;
          end else if (state_q == REQ && master_gnt_i) begin
            state_d = WAIT;
          end
        end
      end
    endcase
  end

  // State and register update with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      sbaddress_q     <= '0;
      sbdata_q        <= '0;
      sbdata_valid_q  <= 1'b0;
      sberror_valid_q <= 1'b0;
      sberror_q       <= '0;
      sbbusyerror_q   <= 1'b0;
      add_q           <= '0;
      we_q            <= 1'b0;
      wdata_q         <= '0;
      be_q            <= '0;
      off_q           <= '0;
      acc_q           <= '0;
      autoinc_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      sbaddress_q     <= sbaddress_d;
      sbdata_q        <= sbdata_d;
      sbdata_valid_q  <= sbdata_valid_d;
      sberror_valid_q <= sberror_valid_d;
      sberror_q       <= sberror_d;
      sbbusyerror_q   <= sbbusyerror_d;
      add_q           <= add_d;
      we_q            <= we_d;
      wdata_q         <= wdata_d;
      be_q            <= be_d;
      off_q           <= off_d;
      acc_q           <= acc_d;
      autoinc_q       <= autoinc_d;
    end
  end

  assign sbaddress_o     = sbaddress_q;
  assign sbdata_o        = sbdata_q;
  assign sbdata_valid_o  = sbdata_valid_q;
  assign sbbusy_o        = (state_q != IDLE);
  assign sberror_valid_o = sberror_valid_q;
  assign sberror_o       = sberror_q;
  assign sbbusyerror_o   = sbbusyerror_q;
  assign master_req_o    = (state_q == REQ);
  assign master_add_o    = add_q;
  assign master_we_o     = we_q;
  assign master_wdata_o  = wdata_q;
  assign master_be_o     = be_q;

endmodule

// File: tb/tb_dm_sba_xfer.sv
// Self-checking bench for dm_sba_xfer: a 32-bit instance driven from a table of
// single transactions plus hand-written corner sequences, and a 64-bit instance
// for the wide access path.
module tb_dm_sba_xfer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  // 32-bit instance signals
  logic        dmactive = 1'b1;
  logic [31:0] addr_in = '0;
  logic        addr_wv = 1'b0, ron_addr = 1'b0, ron_data = 1'b0, autoinc = 1'b0;
  logic [2:0]  acc = '0;
  logic [31:0] data_in = '0;
  logic        data_wv = 1'b0, data_rv = 1'b0;
  logic [31:0] sbaddress, sbdata;
  logic        sbdata_valid, sbbusy, sberr_valid, sbbusyerr;
  logic [2:0]  sberr;
  logic        req, we;
  logic [31:0] add, wdata;
  logic [3:0]  be;
  logic        gnt = 1'b0, rvalid = 1'b0, berr = 1'b0;
  logic [31:0] rdata = '0;

  // 64-bit instance signals
  logic [63:0] w_addr_in = '0, w_data_in = '0, w_rdata = '0;
  logic        w_addr_wv = 1'b0, w_ron = 1'b0, w_data_wv = 1'b0;
  logic [2:0]  w_acc = '0;
  logic [63:0] w_sbaddress, w_sbdata, w_add, w_wdata;
  logic        w_sbdata_valid, w_sbbusy, w_sberr_valid, w_sbbusyerr, w_req, w_we;
  logic [2:0]  w_sberr;
  logic [7:0]  w_be;
  logic        w_gnt = 1'b0, w_rvalid = 1'b0;

  int tests_run = 0;
  int tests_failed = 0;
  logic [31:0] exp_sbdata = '0;

  typedef struct {
    logic        wr;
    logic [2:0]  acc;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] rdata;
    logic        autoinc;
    logic        berr;
    logic [2:0]  exp_err;
    logic [3:0]  exp_be;
    logic [31:0] exp_add;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t vecs[12];

  dm_sba_xfer #(.BusWidth(32), .TimeoutCycles(16)) u_dut32 (
    .clk_i(clk), .rst_i(rst), .dmactive_i(dmactive),
    .sbaddress_i(addr_in), .sbaddress_write_valid_i(addr_wv),
    .sbreadonaddr_i(ron_addr), .sbreadondata_i(ron_data),
    .sbautoincrement_i(autoinc), .sbaccess_i(acc),
    .sbdata_i(data_in), .sbdata_write_valid_i(data_wv),
    .sbdata_read_valid_i(data_rv),
    .sbaddress_o(sbaddress), .sbdata_o(sbdata), .sbdata_valid_o(sbdata_valid),
    .sbbusy_o(sbbusy), .sberror_valid_o(sberr_valid), .sberror_o(sberr),
    .sbbusyerror_o(sbbusyerr),
    .master_req_o(req), .master_add_o(add), .master_we_o(we),
    .master_wdata_o(wdata), .master_be_o(be),
    .master_gnt_i(gnt), .master_r_valid_i(rvalid),
    .master_r_rdata_i(rdata), .master_err_i(berr)
  );

  dm_sba_xfer #(.BusWidth(64), .TimeoutCycles(16)) u_dut64 (
    .clk_i(clk), .rst_i(rst), .dmactive_i(1'b1),
    .sbaddress_i(w_addr_in), .sbaddress_write_valid_i(w_addr_wv),
    .sbreadonaddr_i(w_ron), .sbreadondata_i(1'b0),
    .sbautoincrement_i(1'b0), .sbaccess_i(w_acc),
    .sbdata_i(w_data_in), .sbdata_write_valid_i(w_data_wv),
    .sbdata_read_valid_i(1'b0),
    .sbaddress_o(w_sbaddress), .sbdata_o(w_sbdata), .sbdata_valid_o(w_sbdata_valid),
    .sbbusy_o(w_sbbusy), .sberror_valid_o(w_sberr_valid), .sberror_o(w_sberr),
    .sbbusyerror_o(w_sbbusyerr),
    .master_req_o(w_req), .master_add_o(w_add), .master_we_o(w_we),
    .master_wdata_o(w_wdata), .master_be_o(w_be),
    .master_gnt_i(w_gnt), .master_r_valid_i(w_rvalid),
    .master_r_rdata_i(w_rdata), .master_err_i(1'b0)
  );

  // Free-running clock, 10 time units per cycle
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Runs one table transaction on the 32-bit instance: load address, trigger,
  // grant one cycle into REQ, respond the cycle after grant, then check results.
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    addr_in = v.addr; addr_wv = 1'b1; ron_addr = !v.wr; acc = v.acc; autoinc = v.autoinc;
    if (v.wr) begin
      @(negedge clk);
      addr_wv = 1'b0; ron_addr = 1'b0; data_in = v.data; data_wv = 1'b1;
    end
    @(negedge clk);
    addr_wv = 1'b0; ron_addr = 1'b0; data_wv = 1'b0;
    if (v.exp_err != 3'd0 && !v.berr) begin
      checkOutput("precheck_err_valid", 64'(sberr_valid), 64'd1);
      checkOutput("precheck_err_code", 64'(sberr), 64'(v.exp_err));
      checkOutput("precheck_no_req", 64'(req), 64'd0);
      checkOutput("precheck_addr", 64'(sbaddress), 64'(v.exp_addr));
    end else begin
      checkOutput("req_asserted", 64'(req), 64'd1);
      checkOutput("busy_asserted", 64'(sbbusy), 64'd1);
      checkOutput("master_add", 64'(add), 64'(v.exp_add));
      checkOutput("master_be", 64'(be), 64'(v.exp_be));
      checkOutput("master_we", 64'(we), 64'(v.wr));
      if (v.wr) checkOutput("master_wdata", 64'(wdata), 64'(v.exp_wdata));
      gnt = 1'b1;
      @(negedge clk);
      gnt = 1'b0; rvalid = 1'b1; rdata = v.rdata; berr = v.berr;
      checkOutput("wait_no_req", 64'(req), 64'd0);
      @(negedge clk);
      rvalid = 1'b0; berr = 1'b0;
      checkOutput("done_not_busy", 64'(sbbusy), 64'd0);
      if (v.berr) begin
        checkOutput("buserr_valid", 64'(sberr_valid), 64'd1);
        checkOutput("buserr_code", 64'(sberr), 64'd2);
        checkOutput("buserr_no_data", 64'(sbdata_valid), 64'd0);
      end else if (!v.wr) begin
        exp_sbdata = v.exp_rdata;
        checkOutput("read_valid", 64'(sbdata_valid), 64'd1);
      end else begin
        checkOutput("write_no_valid", 64'(sbdata_valid), 64'd0);
      end
      checkOutput("sbdata", 64'(sbdata), 64'(exp_sbdata));
      checkOutput("addr_after", 64'(sbaddress), 64'(v.exp_addr));
    end
    autoinc = 1'b0;
  endtask

  initial begin
    int busy_cnt;
    //            wr    acc   addr           data           rdata          ai    berr  err   be     add            wdata          rdata_exp      addr_after
    vecs[0]  = '{1'b1, 3'd2, 32'h0000_1000, 32'hDEAD_BEEF, 32'h0,         1'b0, 1'b0, 3'd0, 4'hF, 32'h0000_1000, 32'hDEAD_BEEF, 32'h0,         32'h0000_1000};
    vecs[1]  = '{1'b0, 3'd0, 32'h0000_1003, 32'h0,         32'hAABB_CCDD, 1'b0, 1'b0, 3'd0, 4'h8, 32'h0000_1000, 32'h0,         32'h0000_00AA, 32'h0000_1003};
    vecs[2]  = '{1'b0, 3'd1, 32'hFFFF_FFFE, 32'h0,         32'h1234_5678, 1'b1, 1'b0, 3'd0, 4'hC, 32'hFFFF_FFFC, 32'h0,         32'h0000_1234, 32'h0000_0000};
    vecs[3]  = '{1'b0, 3'd1, 32'h0000_2001, 32'h0,         32'h0,         1'b1, 1'b0, 3'd3, 4'h0, 32'h0,         32'h0,         32'h0,         32'h0000_2001};
    vecs[4]  = '{1'b0, 3'd3, 32'h0000_2000, 32'h0,         32'h0,         1'b0, 1'b0, 3'd4, 4'h0, 32'h0,         32'h0,         32'h0,         32'h0000_2000};
    vecs[5]  = '{1'b1, 3'd0, 32'h0000_3001, 32'h0000_005A, 32'h0,         1'b1, 1'b0, 3'd0, 4'h2, 32'h0000_3000, 32'h0000_5A00, 32'h0,         32'h0000_3002};
    vecs[6]  = '{1'b1, 3'd1, 32'h0000_3002, 32'h0000_BEEF, 32'h0,         1'b0, 1'b0, 3'd0, 4'hC, 32'h0000_3000, 32'hBEEF_0000, 32'h0,         32'h0000_3002};
    vecs[7]  = '{1'b0, 3'd2, 32'h0000_4000, 32'h0,         32'h5555_5555, 1'b1, 1'b1, 3'd2, 4'hF, 32'h0000_4000, 32'h0,         32'h0,         32'h0000_4000};
    vecs[8]  = '{1'b0, 3'd5, 32'h0000_0000, 32'h0,         32'h0,         1'b0, 1'b0, 3'd4, 4'h0, 32'h0,         32'h0,         32'h0,         32'h0000_0000};
    vecs[9]  = '{1'b0, 3'd2, 32'h0000_4002, 32'h0,         32'h0,         1'b0, 1'b0, 3'd3, 4'h0, 32'h0,         32'h0,         32'h0,         32'h0000_4002};
    vecs[10] = '{1'b0, 3'd2, 32'h0000_5004, 32'h0,         32'hCAFE_F00D, 1'b1, 1'b0, 3'd0, 4'hF, 32'h0000_5004, 32'h0,         32'hCAFE_F00D, 32'h0000_5008};
    vecs[11] = '{1'b0, 3'd1, 32'h0000_7002, 32'h0,         32'h8899_AABB, 1'b0, 1'b0, 3'd0, 4'hC, 32'h0000_7000, 32'h0,         32'h0000_8899, 32'h0000_7002};

    // Reset values
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", 64'(sbbusy), 64'd0);
    checkOutput("reset_req", 64'(req), 64'd0);
    checkOutput("reset_sbaddress", 64'(sbaddress), 64'd0);
    checkOutput("reset_sbdata", 64'(sbdata), 64'd0);
    checkOutput("reset_be", 64'(be), 64'd0);
    checkOutput("reset_pulses", {61'd0, sbdata_valid, sberr_valid, sbbusyerr}, 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) applyStimulus(vecs[i]);

    // Triggers and address writes arriving in WAIT are dropped and flagged
    @(negedge clk); addr_in = 32'h8000; addr_wv = 1'b1; acc = 3'd2;
    @(negedge clk); addr_wv = 1'b0; data_in = 32'h1111_1111; data_wv = 1'b1;
    @(negedge clk); data_wv = 1'b0; gnt = 1'b1;
    @(negedge clk); gnt = 1'b0; data_in = 32'h2222_2222; data_wv = 1'b1;
    @(negedge clk); data_wv = 1'b0;
    checkOutput("busyerr_write", 64'(sbbusyerr), 64'd1);
    addr_in = 32'h9000; addr_wv = 1'b1;
    @(negedge clk); addr_wv = 1'b0;
    checkOutput("busyerr_addr", 64'(sbbusyerr), 64'd1);
    rvalid = 1'b1;
    @(negedge clk); rvalid = 1'b0;
    checkOutput("busyerr_done", 64'(sbbusy), 64'd0);
    checkOutput("busyerr_addr_kept", 64'(sbaddress), 64'h8000);
    @(negedge clk);
    checkOutput("busyerr_no_second_req", 64'(req), 64'd0);

    // Timeout: no grant ever arrives
    @(negedge clk); addr_in = 32'h6000; addr_wv = 1'b1; ron_addr = 1'b1; acc = 3'd2;
    @(negedge clk); addr_wv = 1'b0; ron_addr = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      if (sbbusy && req) busy_cnt++;
      @(negedge clk);
    end
    checkOutput("timeout_busy_cycles", 64'(busy_cnt), 64'd16);
    checkOutput("timeout_err_valid", 64'(sberr_valid), 64'd1);
    checkOutput("timeout_err_code", 64'(sberr), 64'd1);
    checkOutput("timeout_req_dropped", 64'(req), 64'd0);
    rvalid = 1'b1; rdata = 32'hFFFF_FFFF;
    @(negedge clk); rvalid = 1'b0;
    checkOutput("late_resp_no_data", 64'(sbdata_valid), 64'd0);
    checkOutput("late_resp_sbdata", 64'(sbdata), 64'(exp_sbdata));
    checkOutput("late_resp_not_busy", 64'(sbbusy), 64'd0);

    // dmactive dropped mid-WAIT, then triggers ignored while inactive
    @(negedge clk); addr_in = 32'hA000; addr_wv = 1'b1; ron_addr = 1'b1; acc = 3'd2;
    @(negedge clk); addr_wv = 1'b0; ron_addr = 1'b0; gnt = 1'b1;
    @(negedge clk); gnt = 1'b0; dmactive = 1'b0;
    @(negedge clk);
    checkOutput("dmoff_idle", 64'(sbbusy), 64'd0);
    checkOutput("dmoff_no_err", 64'(sberr_valid), 64'd0);
    addr_in = 32'hB000; addr_wv = 1'b1; ron_addr = 1'b1;
    @(negedge clk); addr_wv = 1'b0; ron_addr = 1'b0;
    checkOutput("dmoff_no_req", 64'(req), 64'd0);
    checkOutput("dmoff_no_busyerr", 64'(sbbusyerr), 64'd0);
    checkOutput("dmoff_addr_held", 64'(sbaddress), 64'hA000);
    dmactive = 1'b1;

    // 64-bit instance: doubleword write then an upper-lane word read
    @(negedge clk); w_addr_in = 64'h8; w_addr_wv = 1'b1;
    @(negedge clk); w_addr_wv = 1'b0; w_data_in = 64'h1122_3344_5566_7788; w_data_wv = 1'b1; w_acc = 3'd3;
    @(negedge clk); w_data_wv = 1'b0;
    checkOutput("w64_req", 64'(w_req), 64'd1);
    checkOutput("w64_be", 64'(w_be), 64'hFF);
    checkOutput("w64_add", w_add, 64'h8);
    checkOutput("w64_wdata", w_wdata, 64'h1122_3344_5566_7788);
    w_gnt = 1'b1;
    @(negedge clk); w_gnt = 1'b0; w_rvalid = 1'b1;
    @(negedge clk); w_rvalid = 1'b0;
    checkOutput("w64_done", 64'(w_sbbusy), 64'd0);
    w_addr_in = 64'hC; w_addr_wv = 1'b1; w_ron = 1'b1; w_acc = 3'd2;
    @(negedge clk); w_addr_wv = 1'b0; w_ron = 1'b0;
    checkOutput("r64_be", 64'(w_be), 64'hF0);
    checkOutput("r64_add", w_add, 64'h8);
    w_gnt = 1'b1;
    @(negedge clk); w_gnt = 1'b0; w_rvalid = 1'b1; w_rdata = 64'hAABB_CCDD_1122_3344;
    @(negedge clk); w_rvalid = 1'b0;
    checkOutput("r64_valid", 64'(w_sbdata_valid), 64'd1);
    checkOutput("r64_sbdata", w_sbdata, 64'hAABB_CCDD);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/dm_sba_xfer.md
Name: dm_sba_xfer

Overview:
- Next-generation system bus access (SBA) engine for the debug module.
- Generalises the existing fixed-width SBA path in four ways:
  - parametrised bus width of 32 or 64 bits, with byte-lane steering for 8/16/32/64-bit accesses;
  - alignment and size checking;
  - bus error reporting;
  - a transaction timeout.
- Sits between the debug CSR block (sbcs/sbaddress/sbdata) and the host bus port of the debug top level.

Parameters:
- BusWidth, 32, host bus data and address width; legal values are 32 and 64.
- TimeoutCycles, 1024, cycles allowed per transaction before sberror=1 is raised; 0 disables the timeout.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- dmactive_i  in  1  debug module active; low aborts and holds the block idle
- sbaddress_i  in  BusWidth  new address value from the CSRs
- sbaddress_write_valid_i  in  1  load sbaddress_i; triggers a read if sbreadonaddr_i is set
- sbreadonaddr_i  in  1  read-on-address-write enable
- sbreadondata_i  in  1  read-on-data-read enable
- sbautoincrement_i  in  1  increment the address after each successful access
- sbaccess_i  in  3  access size code: 0=8, 1=16, 2=32, 3=64, 4=128 bits
- sbdata_i  in  BusWidth  write data, right-aligned
- sbdata_write_valid_i  in  1  trigger a write
- sbdata_read_valid_i  in  1  sbdata read by the debugger; triggers a read if sbreadondata_i is set
- sbaddress_o  out  BusWidth  current address register
- sbdata_o  out  BusWidth  read data, right-aligned and zero-extended
- sbdata_valid_o  out  1  one-cycle pulse: sbdata_o updated
- sbbusy_o  out  1  transaction in progress
- sberror_valid_o  out  1  one-cycle pulse qualifying sberror_o
- sberror_o  out  3  error code: 1 timeout, 2 bus error, 3 misaligned, 4 unsupported size
- sbbusyerror_o  out  1  one-cycle pulse: trigger arrived while busy
- master_req_o  out  1  bus request
- master_add_o  out  BusWidth  bus address, bus-word aligned
- master_we_o  out  1  write enable
- master_wdata_o  out  BusWidth  lane-steered write data
- master_be_o  out  BusWidth/8  byte enables
- master_gnt_i  in  1  request granted
- master_r_valid_i  in  1  response valid
- master_r_rdata_i  in  BusWidth  read data
- master_err_i  in  1  bus error, qualified by master_r_valid_i

Behaviour:
- Reset (rst_i=1 at a clock edge): state=IDLE; every output is 0, including sbaddress_o and sbdata_o; timeout counter cleared.
- FSM states: IDLE, REQ, WAIT.
  - IDLE -> REQ on an accepted trigger.
  - REQ holds master_req_o=1 with address, we, wdata and be stable until master_gnt_i=1, then goes to WAIT.
  - WAIT -> IDLE on master_r_valid_i=1.
  - master_r_valid_i in the grant cycle itself is ignored; the response is expected at least one cycle after the grant.
- Triggers:
  - Write: sbdata_write_valid_i.
  - Read: (sbaddress_write_valid_i & sbreadonaddr_i) | (sbdata_read_valid_i & sbreadondata_i).
  - Write has priority over read in the same cycle.
- Address load:
  - sbaddress_write_valid_i in IDLE loads sbaddress_o at the next edge.
  - A trigger in that same cycle uses the new address.
- Trigger while not IDLE:
  - The trigger is dropped and sbbusyerror_o pulses at the next edge.
  - An address write while busy is also dropped and flagged the same way.
- Pre-checks in IDLE, evaluated before any bus transaction:
  - Size check: if (8<<sbaccess) > BusWidth, or sbaccess > 4, the access is unsupported → error 4.
  - Alignment check: if the address is not a multiple of the size in bytes → error 3.
  - On either error: no bus request; sberror_valid_o pulses on the next cycle; the FSM stays in IDLE; the address is unchanged.
- Lane steering:
  - off = addr[log2(BusWidth/8)-1:0].
  - master_add_o = addr with its low off bits cleared.
  - master_be_o = ((1<<bytes)-1) << off.
  - master_wdata_o = sbdata_i << (8*off).
  - Read: sbdata_o = (rdata >> 8*off), masked to the access size.
- Latency:
  - Trigger at cycle N → master_req_o=1 and sbbusy_o=1 at N+1.
  - master_r_valid_i at cycle M → at M+1: sbbusy_o=0, sbdata_o/sbdata_valid_o updated (reads only), address incremented.
- Autoincrement: sbaddress += bytes, only on an error-free completion; wraps modulo 2^BusWidth.
- Bus error: master_err_i=1 with master_r_valid_i → error 2; no sbdata update; no increment.
- Timeout:
  - The counter runs in REQ and WAIT and resets on return to IDLE.
  - Reaching TimeoutCycles → error 2 is NOT used; error 1 is raised, master_req_o drops, and the FSM goes to IDLE.
  - A late response while IDLE is ignored.
- dmactive_i=0: the FSM is forced to IDLE at the next edge and master_req_o drops; no error pulse; triggers are ignored; registers hold their values.

Test Plan:
- BusWidth=32: write sbaccess=2 to addr 0x1000 with data 0xDEADBEEF, gnt at N+2, r_valid at N+3 → master_be_o=0xF, master_add_o=0x1000, sbbusy_o deasserts at N+4.
- BusWidth=32, read-on-addr, sbaccess=0, addr 0x1003, rdata 0xAABBCCDD → master_be_o=0x8, master_add_o=0x1000, sbdata_o=0xAA with sbdata_valid_o pulse.
- Autoincrement: sbaccess=1, addr 0xFFFFFFFE, read → sbaddress_o=0x00000000 after completion (wrap); then addr 0x2001 with sbaccess=1 → error 3, no master_req_o.
- BusWidth=32 with sbaccess=3 → error 4; BusWidth=64 with sbaccess=3 at addr 0x8 → master_be_o=0xFF.
- TimeoutCycles=16, gnt never asserted → sberror_o=1 pulse after 16 busy cycles; master_req_o drops; a later r_valid is ignored.
- Write trigger during WAIT → sbbusyerror_o pulse and no second transaction; master_err_i on a read → sberror_o=2 and address not incremented; dmactive_i low mid-WAIT → IDLE next cycle, no error pulse.
